// File: rtl/alu_pkg.sv
// Shared ALU definitions: op code constants and the requester id type.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_EQ  = 4'b1000;

  // Bit 0 of req_valid is the pipeline EX stage, bit 1 the auxiliary unit.
  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_AUX = 1'b1
  } req_id_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; undefined op codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  input  logic [OPCODE_LENGTH-1:0] op,
  output logic [DATA_WIDTH-1:0]    result
);

  always_comb begin
    result = '0;
    case (op)
      OPCODE_LENGTH'(ALU_AND): result = a & b;
      OPCODE_LENGTH'(ALU_OR):  result = a | b;
      OPCODE_LENGTH'(ALU_ADD): result = a + b;
      OPCODE_LENGTH'(ALU_XOR): result = a ^ b;
      OPCODE_LENGTH'(ALU_EQ):  result = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      default:                 result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU behind a single-entry registered result slot.
// Define ALU_ARB_ROUND_ROBIN_EN to alternate ties; otherwise requester 0 wins ties.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_id
);

  logic [1:0]               grant;
  logic                     slot_free;
  logic                     accept;
  req_id_t                  sel;
  req_id_t                  rsp_id_q;
  logic [DATA_WIDTH-1:0]    alu_a;
  logic [DATA_WIDTH-1:0]    alu_b;
  logic [OPCODE_LENGTH-1:0] alu_op;
  logic [DATA_WIDTH-1:0]    alu_result;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  req_id_t last_grant;
`endif

  // A result drained this cycle frees the slot for a same-cycle accept.
  assign slot_free = !rsp_valid || rsp_ready;

  always_comb begin
    grant = 2'b00;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (req_valid == 2'b11)
      grant = (last_grant == REQ_EX) ? 2'b10 : 2'b01;
    else
      grant = req_valid;
`else
    if (req_valid[0])
      grant = 2'b01;
    else if (req_valid[1])
      grant = 2'b10;
`endif
  end

  assign req_ready = reset ? 2'b00 : (grant & {2{slot_free}});
  assign accept    = |(req_valid & req_ready);
  assign sel       = grant[1] ? REQ_AUX : REQ_EX;

  always_comb begin
    alu_a  = req0_a;
    alu_b  = req0_b;
    alu_op = req0_op;
    if (sel == REQ_AUX) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  alu #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_LENGTH(OPCODE_LENGTH)
  ) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .op    (alu_op),
    .result(alu_result)
  );

  // Result slot: load on accept (even while draining), clear when drained idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id_q  <= REQ_EX;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_result;
      rsp_id_q  <= sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Reset to the auxiliary unit so the first tie goes to the EX stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_grant <= REQ_AUX;
    else if (accept)
      last_grant <= sel;
  end
`endif

  assign rsp_id = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter; tie expectations follow ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int OW = 4;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_id;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;

  alu_share_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  // Independent reference for the op code table.
  function automatic logic [DW-1:0] model_alu(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a ^ b;
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 2'b11;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_id got %b want 0", rsp_id); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got %b want 00", req_ready); end
    tick();
    req_valid = 2'b00;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_valid = 2'b01; req0_a = 5; req0_b = 7; req0_op = 4'b0010; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready got %b want 01", req_ready); end
    sb.push_back('{id: 1'b0, data: 32'd12});
    tick();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", rsp_valid); end
    if (sb.size() == 0) begin checks++; errors++; $display("[TB] FAIL single_sb empty"); end
    else begin
      e = sb.pop_front();
      checks++; if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL single_data got %h want %h", rsp_data, e.data); end
      checks++; if (rsp_id !== e.id) begin errors++; $display("[TB] FAIL single_id got %b want %b", rsp_id, e.id); end
    end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %b want 0", rsp_valid); end
  endtask

  task automatic test_tie();
    logic       exp_id;
    logic [1:0] exp_ready;
    reset = 1'b1; #2; reset = 1'b0;
    req0_a = 1; req0_b = 1; req0_op = 4'b0010;
    req1_a = 32'h10; req1_b = 32'h01; req1_op = 4'b0001;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b11;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_id = i[0];
`else
      exp_id = 1'b0;
`endif
      exp_ready = exp_id ? 2'b10 : 2'b01;
      #1;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("[TB] FAIL tie_ready[%0d] got %b want %b", i, req_ready, exp_ready); end
      sb.push_back('{id: exp_id, data: exp_id ? model_alu(req1_op, req1_a, req1_b) : model_alu(req0_op, req0_a, req0_b)});
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL tie_valid[%0d] got %b want 1", i, rsp_valid); end
      if (sb.size() == 0) begin checks++; errors++; $display("[TB] FAIL tie_sb empty"); end
      else begin
        e = sb.pop_front();
        checks++; if (rsp_id !== e.id) begin errors++; $display("[TB] FAIL tie_id[%0d] got %b want %b", i, rsp_id, e.id); end
        checks++; if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL tie_data[%0d] got %h want %h", i, rsp_data, e.data); end
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    req_valid = 2'b01; req0_a = 32'hC; req0_b = 32'hA; req0_op = 4'b0000; rsp_ready = 1'b1;
    #1;
    sb.push_back('{id: 1'b0, data: 32'h8});
    tick();
    req_valid = 2'b10; req1_a = 32'hF0; req1_b = 32'hFF; req1_op = 4'b0100; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready[%0d] got %b want 00", i, req_ready); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d] got %b want 1", i, rsp_valid); end
      checks++; if (rsp_data !== 32'h8) begin errors++; $display("[TB] FAIL bp_hold[%0d] got %h want 8", i, rsp_data); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL bp_release_ready got %b want 10", req_ready); end
    if (sb.size() == 0) begin checks++; errors++; $display("[TB] FAIL bp_sb empty"); end
    else begin
      e = sb.pop_front();
      checks++; if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL bp_drain_data got %h want %h", rsp_data, e.data); end
    end
    sb.push_back('{id: 1'b1, data: model_alu(req1_op, req1_a, req1_b)});
    tick();
    req_valid = 2'b00;
    if (sb.size() == 0) begin checks++; errors++; $display("[TB] FAIL bp_sb empty"); end
    else begin
      e = sb.pop_front();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_valid got %b want 1", rsp_valid); end
      checks++; if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL bp_next_data got %h want %h", rsp_data, e.data); end
      checks++; if (rsp_id !== e.id) begin errors++; $display("[TB] FAIL bp_next_id got %b want %b", rsp_id, e.id); end
    end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle got %b want 0", rsp_valid); end
  endtask

  task automatic test_opcodes();
    logic [OW-1:0] ops[6] = '{4'b1000, 4'b1000, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
    logic [DW-1:0] as[6]  = '{32'd9, 32'd9, 32'h5, 32'hC, 32'hC, 32'hFFFF_FFFF};
    logic [DW-1:0] bs[6]  = '{32'd9, 32'd8, 32'h3, 32'hA, 32'hA, 32'h1};
    rsp_ready = 1'b1;
    req0_a = 32'hDEAD; req0_b = 32'hBEEF; req0_op = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      req_valid = 2'b10; req1_a = as[i]; req1_b = bs[i]; req1_op = ops[i];
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("[TB] FAIL op_ready[%0d] got %b want 10", i, req_ready); end
      sb.push_back('{id: 1'b1, data: model_alu(ops[i], as[i], bs[i])});
      tick();
      if (sb.size() == 0) begin checks++; errors++; $display("[TB] FAIL op_sb empty"); end
      else begin
        e = sb.pop_front();
        checks++; if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL op_data[%0d] got %h want %h", i, rsp_data, e.data); end
        checks++; if (rsp_id !== e.id) begin errors++; $display("[TB] FAIL op_id[%0d] got %b want %b", i, rsp_id, e.id); end
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; req0_a = 2; req0_b = 3; req0_op = 4'b0010; rsp_ready = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd5) begin errors++; $display("[TB] FAIL mid_pending got %b/%h want 1/5", rsp_valid, rsp_data); end
    req_valid = 2'b11;
    req1_a = 4; req1_b = 4; req1_op = 4'b1000;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("[TB] FAIL mid_async_data got %h want 0", rsp_data); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL mid_ready got %b want 00", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("[TB] FAIL mid_hold got %b/%b want 0/00", rsp_valid, req_ready); end
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL mid_first_tie got %b want 01", req_ready); end
    sb.push_back('{id: 1'b0, data: model_alu(req0_op, req0_a, req0_b)});
    tick();
    req_valid = 2'b00;
    if (sb.size() == 0) begin checks++; errors++; $display("[TB] FAIL mid_sb empty"); end
    else begin
      e = sb.pop_front();
      checks++; if (rsp_id !== e.id || rsp_data !== e.data) begin errors++; $display("[TB] FAIL mid_result got %b/%h want %b/%h", rsp_id, rsp_data, e.id, e.data); end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b01; req0_a = 32'(i * 3); req0_b = 32'd100; req0_op = 4'b0010;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("[TB] FAIL stream_ready[%0d] got %b want 01", i, req_ready); end
      sb.push_back('{id: 1'b0, data: 32'(i * 3 + 100)});
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_bubble[%0d] got %b want 1", i, rsp_valid); end
      if (sb.size() == 0) begin checks++; errors++; $display("[TB] FAIL stream_sb empty"); end
      else begin
        e = sb.pop_front();
        checks++; if (rsp_data !== e.data) begin errors++; $display("[TB] FAIL stream_data[%0d] got %h want %h", i, rsp_data, e.data); end
      end
    end
    req_valid = 2'b00;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_end got %b want 0", rsp_valid); end
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL sb_leftover got %0d want 0", sb.size()); end
  endtask

  initial begin
    #3;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_opcodes();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
